uart_tx: RTL and testbench

Serial transmitter that consumes bytes from the message sequencer and drives the board TX pin. Frame format is 8 data bits, LSB first, with optional parity and one stop bit. The handshake is level-based: the upstream holds dataReady high until it sees busy rise, then waits for busy to fall before offering the next byte. The sequencer instantiates it as the serial back end, with clock and inverted-reset wiring adjusted to this block's port list.

---
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit serial transmitter, LSB first, optional parity, one stop bit.
// Level handshake: dataReady in IDLE is accepted on that edge; busy covers the whole frame.
module uart_tx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int PARITY = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       dataReady,
  output logic       busy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baud_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic            r_tx;
  logic            r_busy;

  state_t          w_state_next;
  logic [CW-1:0]   w_cnt_next;
  logic [2:0]      w_bit_next;
  logic [7:0]      w_shift_next;
  logic            w_par_next;
  logic            w_tx_next;
  logic            w_busy_next;
  logic            w_last;

  assign w_last = (r_baud_cnt == LAST_CNT);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_baud_cnt + CW'(1);
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_par_next   = r_parity;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (dataReady) begin
          w_state_next = S_START;
          w_shift_next = data;
          w_par_next   = (^data) ^ (PARITY == 2);
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_next = S_DATA;
          w_cnt_next   = '0;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_next = '0;
          if (r_bit_cnt == 3'd7) begin
            w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_next   = r_bit_cnt + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_PARITY: begin
        if (w_last) begin
          w_state_next = S_STOP;
          w_cnt_next   = '0;
        end
      end
      S_STOP: begin
        if (w_last) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Outputs are decoded from the next state so tx/busy change on the same edge as the state.
    w_tx_next   = 1'b1;
    w_busy_next = (w_state_next != S_IDLE);
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = w_par_next;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_cnt_next;
      r_bit_cnt  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_par_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - bench for uart_tx: three instances (no/even/odd parity), CLKS_PER_BIT=4.
// A frame-level model predicts tx/busy every cycle; directed tests pin the model with literals.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic [2:0] rn;
  logic [2:0] dr;
  logic [7:0] dt [3];
  logic [2:0] txw;
  logic [2:0] busyw;

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(40), .BAUD(10), .PARITY(0)) u_dut0 (
    .clk(clk), .reset_n(rn[0]), .data(dt[0]), .dataReady(dr[0]), .busy(busyw[0]), .tx(txw[0]));
  uart_tx #(.CLK_HZ(40), .BAUD(10), .PARITY(1)) u_dut1 (
    .clk(clk), .reset_n(rn[1]), .data(dt[1]), .dataReady(dr[1]), .busy(busyw[1]), .tx(txw[1]));
  uart_tx #(.CLK_HZ(40), .BAUD(10), .PARITY(2)) u_dut2 (
    .clk(clk), .reset_n(rn[2]), .data(dt[2]), .dataReady(dr[2]), .busy(busyw[2]), .tx(txw[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int nslots(input int i);
    return (i == 0) ? 10 : 11;
  endfunction

  function automatic logic [10:0] build_frame(input int i, input logic [7:0] d);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = d;
    if (i != 0) b[9] = (^d) ^ (i == 2);
    b[nslots(i)-1] = 1'b1;
    return b;
  endfunction

  // Model: remaining frame cycles and position within the frame, per instance.
  int          m_rem [3];
  int          m_k   [3];
  logic [10:0] m_bits [3];
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    for (int i = 0; i < 3; i++) begin
      if (!rn[i]) begin
        m_rem[i] = 0;
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
        m_k[i]++;
      end else if (dr[i]) begin
        m_bits[i] = build_frame(i, dt[i]);
        m_rem[i]  = nslots(i) * CPB;
        m_k[i]    = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        logic eb, et;
        eb = (m_rem[i] > 0);
        et = eb ? m_bits[i][m_k[i] / CPB] : 1'b1;
        check($sformatf("model_busy%0d", i), 32'(busyw[i]), 32'(eb));
        check($sformatf("model_tx%0d", i), 32'(txw[i]), 32'(et));
      end
    end
  end

  // Raise dataReady at a negedge and wait for busy; returns at the negedge of frame cycle 0.
  task automatic offer(input int i, input logic [7:0] v, input bit hold);
    bit ok;
    @(negedge clk);
    dr[i] = 1'b1;
    dt[i] = v;
    ok = 0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      if (busyw[i]) ok = 1;
    end
    check($sformatf("accept_seen%0d", i), 32'(ok), 32'd1);
    if (!hold) dr[i] = 1'b0;
  endtask

  // Sample tx mid-slot across a frame; ends at the negedge just after the frame.
  task automatic sample_frame(input int i, output logic [10:0] bits, output int bcnt);
    bits = '1;
    bcnt = 0;
    for (int k = 0; k < nslots(i) * CPB; k++) begin
      if (busyw[i]) bcnt++;
      if (k % CPB == 2) bits[k / CPB] = txw[i];
      @(negedge clk);
    end
    check($sformatf("busy_low_after%0d", i), 32'(busyw[i]), 32'd0);
  endtask

  logic [10:0] bits;
  int          bcnt;
  bit          quiet;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    rn = 3'b000;
    dr = 3'b111;
    for (int i = 0; i < 3; i++) dt[i] = 8'h00;

    // 1: reset held with dataReady high
    repeat (3) begin
      @(negedge clk);
      check("reset_tx", 32'(txw), 32'h7);
      check("reset_busy", 32'(busyw), 32'h0);
    end
    rn = 3'b111;
    @(negedge clk);
    check("first_accept_busy", 32'(busyw), 32'h7);
    check("first_accept_tx", 32'(txw), 32'h0);
    dr = 3'b000;
    repeat (50) @(negedge clk);

    // 2: single byte 0x41, no parity
    offer(0, 8'h41, 0);
    sample_frame(0, bits, bcnt);
    check("t2_bits", 32'(bits[9:0]), 32'h282);
    check("t2_busy_cycles", 32'(bcnt), 32'd40);

    // 3: sequencer handshake ':' then ')'
    offer(0, 8'h3A, 0);
    sample_frame(0, bits, bcnt);
    check("t3_byte0", 32'(bits[8:1]), 32'h3A);
    check("t3_framing0", 32'({bits[9], bits[0]}), 32'h2);
    offer(0, 8'h29, 0);
    sample_frame(0, bits, bcnt);
    check("t3_byte1", 32'(bits[8:1]), 32'h29);
    check("t3_framing1", 32'({bits[9], bits[0]}), 32'h2);
    quiet = 1;
    repeat (60) begin
      @(negedge clk);
      if (busyw[0]) quiet = 0;
    end
    check("t3_no_third_frame", 32'(quiet), 32'd1);

    // 4: back-to-back with dataReady held; data changes mid-frame
    offer(0, 8'h55, 1);
    dt[0] = 8'hAA;
    sample_frame(0, bits, bcnt);
    check("t4_byte0", 32'(bits[8:1]), 32'h55);
    check("t4_busy0", 32'(bcnt), 32'd40);
    @(negedge clk);
    check("t4_gap_one_cycle", 32'(busyw[0]), 32'd1);
    dr[0] = 1'b0;
    sample_frame(0, bits, bcnt);
    check("t4_byte1", 32'(bits[8:1]), 32'hAA);
    check("t4_busy1", 32'(bcnt), 32'd40);
    repeat (3) @(negedge clk);

    // 5: parity variants
    offer(1, 8'h41, 0);
    sample_frame(1, bits, bcnt);
    check("t5_even_41_frame", 32'(bits), 32'h482);
    check("t5_even_41_busy", 32'(bcnt), 32'd44);
    offer(2, 8'h41, 0);
    sample_frame(2, bits, bcnt);
    check("t5_odd_41_par", 32'(bits[9]), 32'd1);
    check("t5_odd_41_busy", 32'(bcnt), 32'd44);
    offer(1, 8'h07, 0);
    sample_frame(1, bits, bcnt);
    check("t5_even_07_par", 32'(bits[9]), 32'd1);

    // 6: reset during data bit 3, then a clean 0xFF frame
    offer(0, 8'h00, 0);
    repeat (17) @(negedge clk);
    rn[0] = 1'b0;
    @(negedge clk);
    check("t6_abort_tx", 32'(txw[0]), 32'd1);
    check("t6_abort_busy", 32'(busyw[0]), 32'd0);
    rn[0] = 1'b1;
    @(negedge clk);
    offer(0, 8'hFF, 0);
    sample_frame(0, bits, bcnt);
    check("t6_ff_bits", 32'(bits[9:0]), 32'h3FE);
    check("t6_ff_busy", 32'(bcnt), 32'd40);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
